// File: rtl/gb_reg_bank.sv
// Ghostbus register bank leaf: RW CSRs, RO status words, local RAM and a handshaked external window.
// Optional external-ack timeout is built when GB_REG_BANK_TIMEOUT_EN is defined.
module gb_reg_bank #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int NREG   = 4,
  parameter int NSTAT  = 2,
  parameter int RAM_AW = 6,
  parameter int RAM_DW = 8,
  parameter int EXT_AW = 4,
  parameter int TO_CYC = 15
) (
  input  logic                                gb_clk,
  input  logic                                gb_rst,
  input  logic [AW-1:0]                       gb_addr,
  input  logic [DW-1:0]                       gb_dout,
  input  logic                                gb_we,
  input  logic                                gb_re,
  output logic [DW-1:0]                       gb_din,
  output logic                                gb_rvalid,
  output logic                                gb_busy,
  output logic [NREG*DW-1:0]                  csr_q,
  output logic [NREG-1:0]                     csr_wstb,
  input  logic [((NSTAT > 0) ? NSTAT : 1)*DW-1:0] stat_in,
  output logic                                ext_req,
  output logic                                ext_we,
  output logic [EXT_AW-1:0]                   ext_addr,
  output logic [DW-1:0]                       ext_wdata,
  input  logic [DW-1:0]                       ext_rdata,
  input  logic                                ext_ack
);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [DW-1:0]       r_csr [NREG];
  logic [NREG-1:0]     r_wstb;
  logic [15:0]         r_wcnt;
  logic [RAM_DW-1:0]   r_ram [2**RAM_AW];
  logic [DW-1:0]       r_din;
  logic                r_rvalid;
  logic [EXT_AW-1:0]   r_ext_addr;
  logic [DW-1:0]       r_ext_wdata;
  logic                r_ext_we;
  logic [DW-1:0]       r_ext_rd;

  logic [8:0]          w_a9;
  logic [1:0]          w_page;
  logic [6:0]          w_off;
  logic                w_acc_we, w_acc_re;
  logic                w_is_ram, w_is_ext;
  logic [DW-1:0]       w_rdata;
  logic                w_err;
  logic                w_to_fire;
  logic                w_unused;

  assign w_a9     = gb_addr[8:0];
  assign w_page   = w_a9[8:7];
  assign w_off    = w_a9[6:0];
  assign w_acc_we = gb_we & ~gb_busy;
  assign w_acc_re = gb_re & ~gb_we & ~gb_busy;
  assign w_is_ram = (w_page == 2'b10) && ((w_off >> RAM_AW) == 7'd0);
  assign w_is_ext = (w_page == 2'b11) && ((w_off >> EXT_AW) == 7'd0);

  // Read data mux; unmapped addresses fall through to zero
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NREG; i++)
      if (w_a9 == 9'(i)) w_rdata = r_csr[i];
    for (int i = 0; i < NSTAT; i++)
      if (w_a9 == 9'(128 + i)) w_rdata = stat_in[i*DW +: DW];
    if (w_a9 == 9'h0FE) w_rdata[0] = w_err;
    if (w_a9 == 9'h0FF) w_rdata[15:0] = r_wcnt;
    if (w_is_ram) w_rdata[RAM_DW-1:0] = r_ram[w_a9[RAM_AW-1:0]];
  end

  always_ff @(posedge gb_clk) begin
    if (w_acc_we && w_is_ram) r_ram[w_a9[RAM_AW-1:0]] <= gb_dout[RAM_DW-1:0];
  end

  // CSR file, write strobes and write counter
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      for (int i = 0; i < NREG; i++) r_csr[i] <= '0;
      r_wstb <= '0;
      r_wcnt <= '0;
    end else begin
      r_wstb <= '0;
      if (w_acc_we) r_wcnt <= r_wcnt + 16'd1;
      for (int i = 0; i < NREG; i++) begin
        if (w_acc_we && (w_a9 == 9'(i))) begin
          r_csr[i]  <= gb_dout;
          r_wstb[i] <= 1'b1;
        end
      end
    end
  end

`ifdef GB_REG_BANK_TIMEOUT_EN
  logic [15:0] r_to_cnt;
  logic        r_err;

  assign w_to_fire = (r_state == S_EXT) && !ext_ack && (r_to_cnt == 16'(TO_CYC - 1));
  assign w_err     = r_err;
  assign w_unused  = ^gb_addr[AW-1:9];

  // Timeout set takes priority over a host clear in the same cycle
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_EXT) ? r_to_cnt + 16'd1 : 16'd0;
      if (w_to_fire) r_err <= 1'b1;
      else if (w_acc_we && (w_a9 == 9'h0FE) && gb_dout[0]) r_err <= 1'b0;
    end
  end
`else
  logic [15:0] w_unused_to;

  assign w_to_fire   = 1'b0;
  assign w_err       = 1'b0;
  assign w_unused_to = 16'(TO_CYC);
  assign w_unused    = ^{gb_addr[AW-1:9], w_unused_to};
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if ((w_acc_we || w_acc_re) && w_is_ext) w_state_nxt = S_EXT;
      S_EXT: begin
        if (ext_ack)        w_state_nxt = S_RESP;
        else if (w_to_fire) w_state_nxt = S_IDLE;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Access sequencing: local reads answer next cycle, window accesses go through EXT/RESP
  always_ff @(posedge gb_clk or posedge gb_rst) begin
    if (gb_rst) begin
      r_state     <= S_IDLE;
      r_din       <= '0;
      r_rvalid    <= 1'b0;
      r_ext_addr  <= '0;
      r_ext_wdata <= '0;
      r_ext_we    <= 1'b0;
      r_ext_rd    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc_re && !w_is_ext) begin
            r_din    <= w_rdata;
            r_rvalid <= 1'b1;
          end
          if ((w_acc_we || w_acc_re) && w_is_ext) begin
            r_ext_addr  <= w_a9[EXT_AW-1:0];
            r_ext_wdata <= gb_dout;
            r_ext_we    <= w_acc_we;
          end
        end
        S_EXT: begin
          if (ext_ack) begin
            if (!r_ext_we) r_ext_rd <= ext_rdata;
          end else if (w_to_fire && !r_ext_we) begin
            r_din    <= DW'(32'hDEADDEAD);
            r_rvalid <= 1'b1;
          end
        end
        S_RESP: begin
          if (!r_ext_we) begin
            r_din    <= r_ext_rd;
            r_rvalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) csr_q[i*DW +: DW] = r_csr[i];
  end

  assign csr_wstb  = r_wstb;
  assign gb_din    = r_din;
  assign gb_rvalid = r_rvalid;
  assign gb_busy   = (r_state != S_IDLE);
  assign ext_req   = (r_state == S_EXT);
  assign ext_we    = r_ext_we && (r_state == S_EXT);
  assign ext_addr  = r_ext_addr;
  assign ext_wdata = r_ext_wdata;

endmodule

// File: tb/tb_gb_reg_bank.sv
// Bench for gb_reg_bank: vector table for local decode plus sequences for the external window and reset.
module tb_gb_reg_bank;

  logic         gb_clk = 1'b0;
  logic         gb_rst;
  logic [11:0]  gb_addr;
  logic [31:0]  gb_dout;
  logic         gb_we, gb_re;
  logic [31:0]  gb_din;
  logic         gb_rvalid, gb_busy;
  logic [127:0] csr_q;
  logic [3:0]   csr_wstb;
  logic [63:0]  stat_in;
  logic         ext_req, ext_we;
  logic [3:0]   ext_addr;
  logic [31:0]  ext_wdata, ext_rdata;
  logic         ext_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic        we;
    logic        re;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];

  gb_reg_bank dut (
    .gb_clk(gb_clk), .gb_rst(gb_rst), .gb_addr(gb_addr), .gb_dout(gb_dout),
    .gb_we(gb_we), .gb_re(gb_re), .gb_din(gb_din), .gb_rvalid(gb_rvalid),
    .gb_busy(gb_busy), .csr_q(csr_q), .csr_wstb(csr_wstb), .stat_in(stat_in),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack)
  );

  always #5 gb_clk = ~gb_clk;
  always @(posedge gb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic re, input logic [11:0] a,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.we = we; v.re = re; v.addr = a; v.wdata = d; v.exp = e;
    return v;
  endfunction

  task automatic push_exp(input logic [31:0] d, input int due);
    exp_t e;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Strobe tasks: called #1 after an edge, return #1 after the sampling edge
  task automatic rd(input logic [11:0] a, input logic [31:0] e);
    gb_re = 1'b1; gb_addr = a;
    push_exp(e, cyc + 1);
    @(posedge gb_clk); #1;
    gb_re = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    gb_we = 1'b1; gb_addr = a; gb_dout = d;
    @(posedge gb_clk); #1;
    gb_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && gb_busy; i++) begin
      @(posedge gb_clk); #1;
    end
    chk("busy_release", gb_busy, 1'b0);
  endtask

  always @(negedge gb_clk) begin : monitor
    exp_t e;
    if (!gb_rst && gb_rvalid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got gb_din=%0h, no read outstanding (cycle %0d)", gb_din, cyc);
      end else begin
        e = sb.pop_front();
        chk("rdata", gb_din, e.data);
        if (e.due != 0) chk("rd_latency", cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    gb_rst = 1'b1; gb_addr = '0; gb_dout = '0; gb_we = 1'b0; gb_re = 1'b0;
    stat_in = {32'h0BADF00D, 32'h12345678};
    ext_rdata = '0; ext_ack = 1'b0;

    vecs[0]  = mk(0, 1, 12'h001, 32'h0, 32'h0);
    vecs[1]  = mk(0, 1, 12'h080, 32'h0, 32'h12345678);
    vecs[2]  = mk(0, 1, 12'h0FF, 32'h0, 32'h0);
    vecs[3]  = mk(1, 0, 12'h002, 32'hA5A5A5A5, 32'h0);
    vecs[4]  = mk(0, 1, 12'h002, 32'h0, 32'hA5A5A5A5);
    vecs[5]  = mk(0, 1, 12'h0FF, 32'h0, 32'h1);
    vecs[6]  = mk(1, 0, 12'h13F, 32'h1FF, 32'h0);
    vecs[7]  = mk(0, 1, 12'h13F, 32'h0, 32'hFF);
    vecs[8]  = mk(0, 1, 12'h140, 32'h0, 32'h0);
    vecs[9]  = mk(1, 0, 12'h081, 32'h12, 32'h0);
    vecs[10] = mk(0, 1, 12'h081, 32'h0, 32'h0BADF00D);
    vecs[11] = mk(1, 0, 12'h050, 32'h77, 32'h0);
    vecs[12] = mk(0, 1, 12'h050, 32'h0, 32'h0);
    vecs[13] = mk(0, 1, 12'hE02, 32'h0, 32'hA5A5A5A5);
    vecs[14] = mk(1, 0, 12'h0FF, 32'h1234, 32'h0);
    vecs[15] = mk(0, 1, 12'h0FF, 32'h0, 32'h5);
    vecs[16] = mk(1, 1, 12'h003, 32'h55, 32'h0);
    vecs[17] = mk(0, 1, 12'h003, 32'h0, 32'h55);
    vecs[18] = mk(0, 1, 12'h0FE, 32'h0, 32'h0);
    vecs[19] = mk(0, 1, 12'h000, 32'h0, 32'h0);

    repeat (3) @(posedge gb_clk);
    #1;
    chk("rst_din", gb_din, 32'h0);
    chk("rst_rvalid", gb_rvalid, 1'b0);
    chk("rst_csr_q", csr_q, 64'h0);
    chk("rst_csr_q_hi", csr_q[127:64], 64'h0);
    chk("rst_wstb", csr_wstb, 4'h0);
    chk("rst_ext", {ext_req, ext_we, ext_addr}, 6'h0);
    chk("rst_ext_wdata", ext_wdata, 32'h0);
    chk("rst_busy", gb_busy, 1'b0);
    gb_rst = 1'b0;
    @(posedge gb_clk); #1;

    // Local decode vectors, back to back
    for (int i = 0; i < 20; i++) begin
      gb_we = vecs[i].we; gb_re = vecs[i].re;
      gb_addr = vecs[i].addr; gb_dout = vecs[i].wdata;
      if (vecs[i].re && !vecs[i].we) push_exp(vecs[i].exp, cyc + 1);
      @(posedge gb_clk); #1;
    end
    gb_we = 1'b0; gb_re = 1'b0;

    wr(12'h001, 32'h11111111);
    chk("wstb_pulse", csr_wstb, 4'b0010);
    chk("csr_q1", csr_q[63:32], 32'h11111111);
    chk("csr_q2", csr_q[95:64], 32'hA5A5A5A5);
    @(posedge gb_clk); #1;
    chk("wstb_clear", csr_wstb, 4'b0000);

    // External read, ack after 4 cycles, write attempt while busy
    k = cyc;
    gb_re = 1'b1; gb_addr = 12'h183;
    push_exp(32'hCAFEF00D, k + 6);
    @(posedge gb_clk); #1;
    gb_re = 1'b0;
    chk("ext_req_rise", ext_req, 1'b1);
    chk("ext_addr", ext_addr, 4'h3);
    chk("ext_we_rd", ext_we, 1'b0);
    chk("busy_ext", gb_busy, 1'b1);
    for (int j = 0; j < 3; j++) begin
      if (j == 1) begin gb_we = 1'b1; gb_addr = 12'h000; gb_dout = 32'hFFFFFFFF; end
      @(posedge gb_clk); #1;
      gb_we = 1'b0;
      chk("busy_hold", {gb_busy, ext_req}, 2'b11);
    end
    ext_ack = 1'b1; ext_rdata = 32'hCAFEF00D;
    @(posedge gb_clk); #1;
    ext_ack = 1'b0; ext_rdata = '0;
    chk("ext_req_fall", ext_req, 1'b0);
    chk("busy_resp", gb_busy, 1'b1);
    @(posedge gb_clk); #1;
    chk("busy_done", gb_busy, 1'b0);
    rd(12'h000, 32'h0);
    rd(12'h0FF, 32'h7);

    // External write: no read response expected
    wr(12'h185, 32'h42);
    chk("extw_sig", {ext_req, ext_we, ext_addr}, {1'b1, 1'b1, 4'h5});
    chk("extw_data", ext_wdata, 32'h42);
    ext_ack = 1'b1;
    @(posedge gb_clk); #1;
    ext_ack = 1'b0;
    chk("extw_req_fall", ext_req, 1'b0);
    wait_idle();
    rd(12'h0FF, 32'h8);

`ifdef GB_REG_BANK_TIMEOUT_EN
    k = cyc;
    gb_re = 1'b1; gb_addr = 12'h18A;
    push_exp(32'hDEADDEAD, k + 16);
    @(posedge gb_clk); #1;
    gb_re = 1'b0;
    wait_idle();
    chk("to_req_low", ext_req, 1'b0);
    rd(12'h0FE, 32'h1);
    wr(12'h0FE, 32'h1);
    rd(12'h0FE, 32'h0);
`else
    gb_re = 1'b1; gb_addr = 12'h18A;
    push_exp(32'h600DF00D, 0);
    @(posedge gb_clk); #1;
    gb_re = 1'b0;
    repeat (20) @(posedge gb_clk);
    #1;
    chk("noto_wait", {gb_busy, ext_req}, 2'b11);
    ext_ack = 1'b1; ext_rdata = 32'h600DF00D;
    @(posedge gb_clk); #1;
    ext_ack = 1'b0; ext_rdata = '0;
    wait_idle();
    rd(12'h0FE, 32'h0);
`endif

    // Reset while the window access is outstanding
    gb_re = 1'b1; gb_addr = 12'h181;
    @(posedge gb_clk); #1;
    gb_re = 1'b0;
    chk("rst_pre_req", ext_req, 1'b1);
    @(posedge gb_clk); #3;
    gb_rst = 1'b1;
    #1;
    chk("rst_async_req", {ext_req, gb_busy}, 2'b00);
    @(posedge gb_clk); #1;
    gb_rst = 1'b0;
    repeat (4) @(posedge gb_clk);
    #1;
    chk("rst_csr_clear", csr_q, 128'h0);
    rd(12'h0FF, 32'h0);
    k = cyc;
    gb_re = 1'b1; gb_addr = 12'h181;
    push_exp(32'h13579BDF, k + 3);
    @(posedge gb_clk); #1;
    gb_re = 1'b0;
    chk("post_rst_addr", ext_addr, 4'h1);
    ext_ack = 1'b1; ext_rdata = 32'h13579BDF;
    @(posedge gb_clk); #1;
    ext_ack = 1'b0; ext_rdata = '0;
    wait_idle();

    repeat (3) @(posedge gb_clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
